run_detect_arbiter: RTL

- Shares one run-length detector datapath among NCH requesters. Each requester supplies a serial bit stream.
- A round-robin arbiter grants one channel per cycle. The block loads that channel's saved context, updates the run count with its bit, writes the context back and reports a registered result.
- Per channel this is equivalent to the single-stream detector: z is high once the last RUN_LEN accepted bits are identical, and stays high while the run continues.
- Sits between the sampling front-ends and the event/status logic.

---
 rtl/run_detect_pkg.sv | 26 ++
 rtl/run_detect_arbiter_rr_arbiter.sv | 48 ++++
 rtl/run_detect_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/run_detect_pkg.sv
// Shared types and helpers for the multi-channel run-length detector.
package run_detect_pkg;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic             seen;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } ctx_t;

  function automatic int chw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int cw(input int r);
    return $clog2(r + 1);
  endfunction

  function automatic logic [CNT_W-1:0] next_cnt(input ctx_t ctx, input logic b, input int run_len);
    if (!ctx.seen || (ctx.last != b)) return CNT_W'(1);
    if (ctx.cnt >= CNT_W'(run_len)) return CNT_W'(run_len);
    return ctx.cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/run_detect_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, with wrap-around.
module rr_arbiter
  import run_detect_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int CHW = chw(NCH)
) (
  input  logic           clk,
  input  logic           aclr,
  input  logic           en,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] idx
);

  logic [CHW-1:0] ptr;
  logic [CHW-1:0] jj;
  logic           found;
  int unsigned    j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    if (aclr && en) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        j  = (int'(ptr) + i) % NCH;
        jj = CHW'(j);
        if (!found && req[jj]) begin
          found   = 1'b1;
          gnt[jj] = 1'b1;
          idx     = jj;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (idx == CHW'(NCH - 1)) ? '0 : idx + CHW'(1);
    end
  end

endmodule

// File: rtl/run_detect_arbiter.sv
// Time-shared run-length detector: one update datapath serving NCH bit streams
// through round-robin arbitration and per-channel saved contexts.
module run_detect_arbiter
  import run_detect_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int RUN_LEN = 4,
  localparam int CHW     = chw(NCH),
  localparam int CW      = cw(RUN_LEN)
) (
  input  logic           clk,
  input  logic           aclr,
  input  logic           en,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] w,
  input  logic [NCH-1:0] clr,
  output logic [NCH-1:0] gnt,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic           out_z,
  output logic [CW-1:0]  out_cnt,
  output logic [NCH-1:0] z_stat
);

  ctx_t           ctx   [NCH];
  ctx_t           ctx_n [NCH];
  logic [CHW-1:0] gidx;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk  (clk),
    .aclr (aclr),
    .en   (en),
    .req  (req),
    .gnt  (gnt),
    .idx  (gidx)
  );

  // Clear is folded in before the update so a same-cycle grant sees a fresh context.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      ctx_n[i] = ctx[i];
      if (clr[i]) ctx_n[i] = '0;
      if (gnt[i]) begin
        ctx_n[i].cnt  = next_cnt(ctx_n[i], w[i], RUN_LEN);
        ctx_n[i].seen = 1'b1;
        ctx_n[i].last = w[i];
      end
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int unsigned i = 0; i < NCH; i++) ctx[i] <= '0;
      z_stat    <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_z     <= 1'b0;
      out_cnt   <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ctx[i]    <= ctx_n[i];
        z_stat[i] <= (ctx_n[i].cnt == CNT_W'(RUN_LEN));
      end
      out_valid <= |gnt;
      if (|gnt) begin
        out_ch  <= gidx;
        out_cnt <= ctx_n[gidx].cnt[CW-1:0];
        out_z   <= (ctx_n[gidx].cnt == CNT_W'(RUN_LEN));
      end
    end
  end

endmodule
